// File: rtl/ahb_bus_arbiter.sv
// AHB bus arbiter: 16 masters, round-robin with lock and split support.
// Grant is combinational from the owner register; HMASTER/HMASTLOCK lag one cycle.
module ahb_bus_arbiter (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [15:0] HBUSREQx,
  input  logic [15:0] HLOCKx,
  output logic [15:0] HGRANTx,
  input  logic [15:0] HSPLIT,
  input  logic        HREADY,
  output logic [3:0]  HMASTER,
  output logic        HMASTLOCK
);

  logic        own_vld_q, own_vld_d;
  logic [3:0]  own_idx_q, own_idx_d;
  logic [3:0]  last_idx_q, last_idx_d;
  logic [3:0]  hmaster_q, hmaster_d;
  logic        hmastlock_q, hmastlock_d;

  logic [15:0] elig;
  logic        cur_req;
  logic        keep;
  logic        found;
  logic [3:0]  pick;
  logic [3:0]  cand;

  assign elig    = HBUSREQx & ~HSPLIT;
  assign cur_req = own_vld_q & HBUSREQx[own_idx_q];
  assign keep    = cur_req & HLOCKx[own_idx_q]
                 & ~HSPLIT[own_idx_q];

  assign HGRANTx   = own_vld_q
                   ? ((16'b1 << own_idx_q) & HBUSREQx)
                   : 16'b0;
  assign HMASTER   = hmaster_q;
  assign HMASTLOCK = hmastlock_q;

  // Round-robin scan starting just after the last winner
  always_comb begin
    found = 1'b0;
    pick  = last_idx_q;
    cand  = last_idx_q;
    for (int k = 0; k < 16; k++) begin
      cand = last_idx_q + 4'd1 + 4'(k);
      if (!found && elig[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Next-state: arbitrate and hand over the address phase when HREADY is high
  always_comb begin
    own_vld_d   = own_vld_q;
    own_idx_d   = own_idx_q;
    last_idx_d  = last_idx_q;
    hmaster_d   = hmaster_q;
    hmastlock_d = hmastlock_q;
    if (HREADY) begin
      hmaster_d   = cur_req ? own_idx_q : 4'd0;
      hmastlock_d = cur_req & HLOCKx[own_idx_q];
      if (!keep) begin
        own_vld_d = found;
        if (found) begin
          own_idx_d  = pick;
          last_idx_d = pick;
        end
      end
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      own_vld_q   <= 1'b0;
      own_idx_q   <= 4'd0;
      last_idx_q  <= 4'd15;
      hmaster_q   <= 4'd0;
      hmastlock_q <= 1'b0;
    end else begin
      own_vld_q   <= own_vld_d;
      own_idx_q   <= own_idx_d;
      last_idx_q  <= last_idx_d;
      hmaster_q   <= hmaster_d;
      hmastlock_q <= hmastlock_d;
    end
  end

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Testbench for ahb_bus_arbiter: directed table, corner sequences,
// and a randomized run against a behavioural reference model.
module tb_ahb_bus_arbiter;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [15:0] HBUSREQx;
  logic [15:0] HLOCKx;
  logic [15:0] HGRANTx;
  logic [15:0] HSPLIT;
  logic        HREADY;
  logic [3:0]  HMASTER;
  logic        HMASTLOCK;

  always #5 HCLK = ~HCLK;

  ahb_bus_arbiter dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HBUSREQx  (HBUSREQx),
    .HLOCKx    (HLOCKx),
    .HGRANTx   (HGRANTx),
    .HSPLIT    (HSPLIT),
    .HREADY    (HREADY),
    .HMASTER   (HMASTER),
    .HMASTLOCK (HMASTLOCK)
  );

  typedef struct {
    logic        rstn;
    logic [15:0] req;
    logic [15:0] lock;
    logic [15:0] split;
    logic        rdy;
    logic [15:0] g;
    logic [3:0]  m;
    logic        ml;
  } vec_t;

  typedef struct {
    logic [15:0] g;
    logic [3:0]  m;
    logic        ml;
    int          id;
  } exp_t;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // reference model state
  logic       m_vld;
  logic [3:0] m_own;
  logic [3:0] m_last;
  logic [3:0] m_hm;
  logic       m_hl;

  task automatic chk(string nm, int id,
                     logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s #%0d actual=%h required=%h",
                  nm, id, act, exp);
  endtask

  task automatic model_edge(vec_t v);
    logic       cur;
    logic [3:0] nhm;
    logic       nhl;
    int         j;
    if (!v.rstn) begin
      m_vld = 0; m_own = 0; m_last = 15;
      m_hm = 0; m_hl = 0;
    end else if (v.rdy) begin
      cur = m_vld && v.req[m_own];
      nhm = cur ? m_own : 4'd0;
      nhl = cur && v.lock[m_own];
      if (!(cur && v.lock[m_own] && !v.split[m_own])) begin
        m_vld = 0;
        for (int k = 1; k <= 16; k++) begin
          j = (int'(m_last) + k) % 16;
          if (v.req[j] && !v.split[j]) begin
            m_vld = 1;
            m_own = 4'(j);
            break;
          end
        end
        if (m_vld) m_last = m_own;
      end
      m_hm = nhm;
      m_hl = nhl;
    end
  endtask

  // drive one cycle, queue the expectation, check after the edge
  task automatic apply(vec_t v, bit use_model, int id);
    exp_t e;
    exp_t r;
    HRESETn  = v.rstn;
    HBUSREQx = v.req;
    HLOCKx   = v.lock;
    HSPLIT   = v.split;
    HREADY   = v.rdy;
    model_edge(v);
    if (use_model) begin
      e.g  = m_vld ? ((16'h1 << m_own) & v.req) : 16'h0;
      e.m  = m_hm;
      e.ml = m_hl;
    end else begin
      e.g = v.g; e.m = v.m; e.ml = v.ml;
    end
    e.id = id;
    sbq.push_back(e);
    @(posedge HCLK);
    #1;
    r = sbq.pop_front();
    chk("grant", r.id, 32'(HGRANTx), 32'(r.g));
    chk("hmaster", r.id, 32'(HMASTER), 32'(r.m));
    chk("hmastlock", r.id, 32'(HMASTLOCK), 32'(r.ml));
  endtask

  function automatic vec_t mk(logic rstn, logic [15:0] req,
      logic [15:0] lock, logic [15:0] split, logic rdy,
      logic [15:0] g, logic [3:0] m, logic ml);
    vec_t v;
    v.rstn = rstn; v.req = req; v.lock = lock;
    v.split = split; v.rdy = rdy;
    v.g = g; v.m = m; v.ml = ml;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    vec_t v;
    logic [15:0] seen;
    HRESETn = 0; HBUSREQx = 16'hFFFF; HLOCKx = 0;
    HSPLIT = 0; HREADY = 1;
    m_vld = 0; m_own = 0; m_last = 15; m_hm = 0; m_hl = 0;
    #1;

    // reset
    tbl.push_back(mk(0, 16'hFFFF, 0, 0, 1, 16'h0000, 0, 0));
    tbl.push_back(mk(0, 16'hFFFF, 0, 0, 1, 16'h0000, 0, 0));
    // round-robin 0,2,0
    tbl.push_back(mk(1, 16'h0005, 0, 0, 1, 16'h0001, 0, 0));
    tbl.push_back(mk(1, 16'h0005, 0, 0, 1, 16'h0004, 0, 0));
    tbl.push_back(mk(1, 16'h0005, 0, 0, 1, 16'h0001, 2, 0));
    tbl.push_back(mk(1, 16'h0005, 0, 0, 1, 16'h0004, 0, 0));
    // reset mid-transfer, then lock
    tbl.push_back(mk(0, 16'h0005, 0, 0, 1, 16'h0000, 0, 0));
    tbl.push_back(mk(1, 16'h0028, 16'h0008, 0, 1, 16'h0008, 0, 0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1, 16'h0028, 16'h0008, 0, 1,
                       16'h0008, 3, 1));
    tbl.push_back(mk(1, 16'h0028, 0, 0, 1, 16'h0020, 3, 0));
    tbl.push_back(mk(1, 16'h0028, 0, 0, 1, 16'h0008, 5, 0));
    // wait states
    tbl.push_back(mk(0, 0, 0, 0, 1, 16'h0000, 0, 0));
    tbl.push_back(mk(1, 16'h0002, 0, 0, 1, 16'h0002, 0, 0));
    tbl.push_back(mk(1, 16'h0002, 0, 0, 1, 16'h0002, 1, 0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1, 16'h0082, 0, 0, 0, 16'h0002, 1, 0));
    tbl.push_back(mk(1, 16'h0082, 0, 0, 1, 16'h0080, 1, 0));
    tbl.push_back(mk(1, 16'h0082, 0, 0, 1, 16'h0002, 7, 0));
    // split
    tbl.push_back(mk(0, 0, 0, 0, 1, 16'h0000, 0, 0));
    tbl.push_back(mk(1, 16'h0300, 0, 16'h0100, 1, 16'h0200, 0, 0));
    tbl.push_back(mk(1, 16'h0300, 0, 16'h0100, 1, 16'h0200, 9, 0));
    tbl.push_back(mk(1, 16'h0300, 0, 0, 1, 16'h0100, 9, 0));
    tbl.push_back(mk(1, 16'h0300, 0, 0, 1, 16'h0200, 8, 0));
    // split ends a locked owner
    tbl.push_back(mk(0, 0, 0, 0, 1, 16'h0000, 0, 0));
    tbl.push_back(mk(1, 16'h0011, 16'h0001, 0, 1, 16'h0001, 0, 0));
    tbl.push_back(mk(1, 16'h0011, 16'h0001, 0, 1, 16'h0001, 0, 1));
    tbl.push_back(mk(1, 16'h0011, 16'h0001, 16'h0001, 1,
                     16'h0010, 0, 1));
    tbl.push_back(mk(1, 16'h0011, 16'h0001, 16'h0001, 1,
                     16'h0010, 4, 0));

    foreach (tbl[i]) apply(tbl[i], 1'b0, i);

    // owner drops request: grant falls in the same cycle
    HBUSREQx = 16'h0001;
    #1;
    chk("drop_same_cycle", 100, 32'(HGRANTx), 32'h0);
    apply(mk(1, 16'h0001, 0, 0, 1, 0, 0, 0), 1'b1, 101);
    chk("drop_rearb", 102, 32'(HGRANTx), 32'h0001);

    // fairness: all request, every master granted in 16 points
    apply(mk(0, 0, 0, 0, 1, 0, 0, 0), 1'b1, 200);
    seen = 0;
    for (int i = 0; i < 16; i++) begin
      apply(mk(1, 16'hFFFF, 0, 0, 1, 0, 0, 0), 1'b1, 201 + i);
      seen |= HGRANTx;
    end
    chk("fairness", 220, 32'(seen), 32'hFFFF);

    // randomized run against the model plus invariants
    for (int i = 0; i < 10000; i++) begin
      v.rstn  = ($urandom_range(499) != 0);
      v.req   = 16'($urandom);
      v.lock  = 16'($urandom) & 16'($urandom);
      v.split = 16'($urandom) & 16'($urandom) & 16'($urandom);
      v.rdy   = ($urandom_range(3) != 0);
      apply(v, 1'b1, 1000 + i);
      chk("onehot", 1000 + i,
          32'($countones(HGRANTx) <= 1), 32'h1);
      chk("grant_req", 1000 + i,
          32'(HGRANTx & ~HBUSREQx), 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
